// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the FFT sample path.
// Bit-reversal used by fft_input_buffer when FFT_INPUT_BITREV_EN is defined.
package fft_pkg;

    localparam int FFT_N_POINTS = 256;
    localparam int FFT_ADDR_W   = 8;
    localparam int FFT_DATA_W   = 16;

    typedef logic [FFT_DATA_W-1:0] fft_sample_t;

    typedef enum logic {
        IB_LOAD,
        IB_STREAM
    } ibuf_state_e;

    function automatic logic [FFT_ADDR_W-1:0] fft_bitrev(
        input logic [FFT_ADDR_W-1:0] addr
    );
        return {<<{addr}};
    endfunction

endpackage

// File: rtl/fft_input_buffer_if.sv
// Valid/ready sample stream from the input buffer to the FFT core.
// master drives data/valid, slave drives ready.
interface fft_input_buffer_if
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int IDX_W  = FFT_ADDR_W
);

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_index;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/fft_sample_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// The read register holds when re is low, so it doubles as the output stage.
module fft_sample_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_input_buffer.sv
// Sample buffer: loads from the Avalon slave, streams to the FFT core.
// Define FFT_INPUT_BITREV_EN for bit-reversed read order (DIT core).
module fft_input_buffer
    import fft_pkg::*;
#(
    parameter int N_POINTS = FFT_N_POINTS,
    parameter int DATA_W   = FFT_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sWriteEn,
    input  logic [$clog2(N_POINTS):0]  wAddress,
    input  logic [DATA_W-1:0]          fft_init_data,
    input  logic                       fft_start,
    fft_input_buffer_if.master         out_if,
    output logic                       busy,
    output logic                       overrun
);

    localparam int ADDR_W = $clog2(N_POINTS);

    ibuf_state_e       state;
    ibuf_state_e       state_d;
    logic [ADDR_W-1:0] rd_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic              issue_done;
    logic              issue;
    logic              hs;
    logic              we;

`ifdef FFT_INPUT_BITREV_EN
    assign rd_addr = ADDR_W'(fft_bitrev(FFT_ADDR_W'(rd_cnt))
                     >> (FFT_ADDR_W - ADDR_W));
`else
    assign rd_addr = rd_cnt;
`endif

    assign busy = (state == IB_STREAM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IB_LOAD;
        end else begin
            state <= state_d;
        end
    end

    // issue fetches the next word straight into the RAM read register
    always_comb begin
        state_d = state;
        issue   = 1'b0;
        we      = 1'b0;
        hs      = out_if.out_valid && out_if.out_ready;
        unique case (state)
            IB_LOAD: begin
                we = sWriteEn && !wAddress[ADDR_W];
                if (fft_start) begin
                    state_d = IB_STREAM;
                end
            end
            IB_STREAM: begin
                issue = !issue_done &&
                        (!out_if.out_valid || out_if.out_ready);
                if (hs && out_if.out_last) begin
                    state_d = IB_LOAD;
                end
            end
            default: state_d = IB_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt           <= '0;
            issue_done       <= 1'b0;
            overrun          <= 1'b0;
            out_if.out_valid <= 1'b0;
            out_if.out_index <= '0;
            out_if.out_last  <= 1'b0;
        end else begin
            if (state == IB_LOAD && fft_start) begin
                rd_cnt     <= '0;
                issue_done <= 1'b0;
                overrun    <= 1'b0;
            end
            if (state == IB_STREAM && sWriteEn) begin
                overrun <= 1'b1;
            end
            if (issue) begin
                out_if.out_valid <= 1'b1;
                out_if.out_index <= rd_cnt;
                out_if.out_last  <= (rd_cnt == '1);
                rd_cnt           <= rd_cnt + 1'b1;
                issue_done       <= (rd_cnt == '1);
            end else if (hs) begin
                out_if.out_valid <= 1'b0;
                out_if.out_last  <= 1'b0;
            end
        end
    end

    fft_sample_ram #(
        .DEPTH  (N_POINTS),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (wAddress[ADDR_W-1:0]),
        .wdata (fft_init_data),
        .re    (issue),
        .raddr (rd_addr),
        .rdata (out_if.out_data)
    );

endmodule

// File: tb/tb_fft_input_buffer.sv
// Scoreboard bench for fft_input_buffer with a queue-based reference model.
module tb_fft_input_buffer;
    import fft_pkg::*;

    typedef struct packed {
        fft_sample_t d;
        logic [7:0]  i;
        logic        l;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        sWriteEn;
    logic [8:0]  wAddress;
    fft_sample_t fft_init_data;
    logic        fft_start;
    logic        busy;
    logic        overrun;

    fft_input_buffer_if #(.DATA_W(16), .IDX_W(8)) sif ();

    fft_input_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .sWriteEn      (sWriteEn),
        .wAddress      (wAddress),
        .fft_init_data (fft_init_data),
        .fft_start     (fft_start),
        .out_if        (sif),
        .busy          (busy),
        .overrun       (overrun)
    );

    int          total = 0;
    int          bad = 0;
    int          popped = 0;
    int          last_cnt = 0;
    int          rdy_mode = 0;
    int          cyc = 0;
    exp_t        q[$];
    fft_sample_t model_mem [256];
    bit          model_stream = 0;
    bit          prev_hold = 0;
    logic [24:0] prev_word;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    function automatic int rev8(input int k);
        int r = 0;
        int v = k;
        repeat (8) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
        return r;
    endfunction

    function automatic int src_addr(input int k);
`ifdef FFT_INPUT_BITREV_EN
        return rev8(k);
`else
        return k;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        case (rdy_mode)
            0: sif.out_ready = 1'b1;
            1: sif.out_ready = (cyc % 3 == 0);
            default: sif.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 32'(sif.out_valid), 32'd1);
                chk("hold_word",
                    32'({sif.out_data, sif.out_index, sif.out_last}),
                    32'(prev_word));
            end
            prev_hold = 0;
            if (sif.out_valid && sif.out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_word: got index %0d want none",
                             sif.out_index);
                end else begin
                    e = q.pop_front();
                    chk("data", 32'(sif.out_data), 32'(e.d));
                    chk("index", 32'(sif.out_index), 32'(e.i));
                    chk("last", 32'(sif.out_last), 32'(e.l));
                end
                popped++;
                if (sif.out_last) last_cnt++;
            end else if (sif.out_valid) begin
                prev_hold = 1;
                prev_word = {sif.out_data, sif.out_index, sif.out_last};
            end
        end
    end

    task automatic write(input logic [8:0] a, input fft_sample_t d);
        sWriteEn = 1'b1;
        wAddress = a;
        fft_init_data = d;
        if (!model_stream && !a[8]) model_mem[a[7:0]] = d;
        tick;
        sWriteEn = 1'b0;
    endtask

    task automatic do_start(input bit wr, input logic [8:0] a,
                            input fft_sample_t d);
        fft_start = 1'b1;
        if (wr) begin
            sWriteEn = 1'b1;
            wAddress = a;
            fft_init_data = d;
            if (!a[8]) model_mem[a[7:0]] = d;
        end
        for (int k = 0; k < 256; k++) begin
            q.push_back({model_mem[src_addr(k)], 8'(k), k == 255});
        end
        model_stream = 1;
        tick;
        fft_start = 1'b0;
        sWriteEn = 1'b0;
    endtask

    task automatic wait_end(input string nm);
        int n = 0;
        int l0 = last_cnt;
        while (last_cnt == l0 && n < 3000) begin
            tick;
            n++;
        end
        chk({nm, "_last_seen"}, 32'(last_cnt - l0), 32'd1);
        @(negedge clk);
        chk({nm, "_busy_fall"}, 32'(busy), 32'd0);
        chk({nm, "_q_empty"}, 32'(q.size()), 32'd0);
        model_stream = 0;
        tick;
    endtask

    initial begin
        int n;
        int p0;
        rst = 1'b1;
        sWriteEn = 1'b0;
        wAddress = '0;
        fft_init_data = '0;
        fft_start = 1'b0;
        sif.out_ready = 1'b1;
        repeat (3) tick;
        @(negedge clk);
        chk("rst_valid", 32'(sif.out_valid), 32'd0);
        chk("rst_last", 32'(sif.out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_data", 32'(sif.out_data), 32'd0);
        chk("rst_index", 32'(sif.out_index), 32'd0);
        tick;
        rst = 1'b0;
        tick;

        for (int i = 0; i < 256; i++) begin
            write(9'(i), fft_sample_t'(16'h1000 + i));
        end
        write(9'h100, 16'hDEAD);

        rdy_mode = 0;
        do_start(0, '0, '0);
        @(negedge clk);
        chk("t1_busy_rise", 32'(busy), 32'd1);
        chk("t1_valid_lat1", 32'(sif.out_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid_lat2", 32'(sif.out_valid), 32'd1);
        tick;
        wait_end("t1");
        chk("t1_overrun", 32'(overrun), 32'd0);

        rdy_mode = 1;
        do_start(0, '0, '0);
        wait_end("t2");

        rdy_mode = 0;
        do_start(0, '0, '0);
        repeat (5) tick;
        write(9'h005, 16'h5555);
        @(negedge clk);
        chk("t3_overrun_set", 32'(overrun), 32'd1);
        tick;
        fft_start = 1'b1;
        tick;
        fft_start = 1'b0;
        wait_end("t3");
        chk("t3_overrun_hold", 32'(overrun), 32'd1);

        rdy_mode = 2;
        do_start(0, '0, '0);
        @(negedge clk);
        chk("t4_overrun_clr", 32'(overrun), 32'd0);
        tick;
        wait_end("t4");

        rdy_mode = 0;
        do_start(1, 9'h000, 16'hABCD);
        wait_end("t5");

        do_start(0, '0, '0);
        p0 = popped;
        n = 0;
        while (popped - p0 < 100 && n < 3000) begin
            tick;
            n++;
        end
        chk("t6_words_before_rst", 32'(popped - p0 >= 100), 32'd1);
        rst = 1'b1;
        q.delete();
        tick;
        @(negedge clk);
        chk("t6_rst_valid", 32'(sif.out_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        tick;
        rst = 1'b0;
        model_stream = 0;
        tick;
        rdy_mode = 2;
        do_start(0, '0, '0);
        wait_end("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_input_buffer.md
# fft_input_buffer

Sample store between the Avalon-MM slave front end and the FFT butterfly core. Captures the 16-bit samples the slave delivers through `sWriteEn`/`wAddress`/`fft_init_data` into a 256-entry buffer. On `fft_start` it streams all 256 samples to the FFT core over a valid/ready interface, in bit-reversed address order, which is the input order the radix-2 DIT core requires.

## Interface
- `N_POINTS`, default 256: buffer depth; must be a power of two.
- `DATA_W`, default 16: sample width.
- `clk` input, 1 bit: single clock; all logic is rising-edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `sWriteEn` input, 1 bit: write strobe from the Avalon slave.
- `wAddress` input, 9 bits: sample index. Bit 8 set means out of range.
- `fft_init_data` input, DATA_W bits: sample value.
- `fft_start` input, 1 bit: single-cycle pulse that starts a stream.
- `out_valid` output, 1 bit: `out_data` is valid.
- `out_ready` input, 1 bit: FFT core accepts the current word.
- `out_data` output, DATA_W bits: sample value.
- `out_index` output, 8 bits: natural-order position (0..255) of the word in the stream.
- `out_last` output, 1 bit: marks the final word (index 255).
- `busy` output, 1 bit: high in STREAM state.
- `overrun` output, 1 bit: sticky flag, set when a write is dropped.

## Operation
- The state machine has two states, LOAD and STREAM. Reset state is LOAD.
- In LOAD:
  - `sWriteEn` with `wAddress[8]`=0 writes `fft_init_data` to `mem[wAddress[7:0]]`.
  - Writes with `wAddress[8]`=1 are ignored silently.
  - `fft_start` moves the block to STREAM and clears the read counter `rd_cnt` to 0.
- In STREAM:
  - The read address is `bitrev(rd_cnt)`, `out_index`=`rd_cnt`, and `out_last`=(`rd_cnt`==255).
  - A handshake completes when `out_valid && out_ready`; `rd_cnt` then increments.
  - The handshake on `out_last` returns the block to LOAD.
  - `sWriteEn` in STREAM is dropped and sets `overrun`.
  - `fft_start` in STREAM is ignored.
- `overrun` clears only on `rst` or on the `fft_start` that enters STREAM.
- Buffer contents are not cleared by reset. Entries never written read back as undefined.
- If `fft_start` and `sWriteEn` arrive in the same LOAD cycle, the write commits first and is included in the stream.
- Reset asserted mid-stream returns the block to LOAD immediately. No `out_last` is produced for the aborted stream.

## Timing
- Reset values:
  - `out_valid`=0, `out_last`=0, `busy`=0, `overrun`=0.
  - `out_data`=0, `out_index`=0.
  - `rd_cnt`=0, state=LOAD.
- Memory read latency is 1 cycle. Outputs are registered.
- Start latency: with `fft_start` high in cycle T, `busy`=1 from T+1 and the first `out_valid`=1 at T+2.
- With `out_ready` held high, the block sustains one word per cycle. The 256 words occupy cycles T+2..T+257, and `busy` falls at T+258.
- Back-pressure:
  - While `out_valid && !out_ready`, `out_data`, `out_index` and `out_last` hold stable.
  - `out_valid` never drops before the handshake completes.
  - A prefetch/skid register keeps throughput at one word per cycle when `out_ready` re-asserts.
- `out_valid` must not depend combinationally on `out_ready`.
- A write in cycle T is visible to a stream started at T+1 or later.

## Configuration
- The macro `FFT_INPUT_BITREV_EN` selects the read order.
- Defined: read address = `bitrev(rd_cnt)` over log2(N_POINTS) bits, as used by the DIT core.
- Undefined: read address = `rd_cnt` (natural order), for a DIF core or for debug bypass.
- `out_index` is always the natural-order counter, with or without the macro.

## Structure
- The shared package `fft_pkg` holds:
  - The constants `FFT_N_POINTS`=256, `FFT_ADDR_W`=8 and `FFT_DATA_W`=16.
  - The `fft_sample_t` typedef.
  - The `ibuf_state_e` enum {`IB_LOAD`, `IB_STREAM`}.
  - The function `fft_bitrev(addr)`.
- The one sub-module is `fft_sample_ram`: simple dual-port, one write port and one registered read port, inferable as block RAM.
- The FSM, counter, skid register and flags live in `fft_input_buffer`.

## Test plan
- Load and stream, bit-reversed: write `mem[i]`=16'h1000+i for i=0..255, pulse `fft_start`, hold `out_ready`=1.
  - Expect 256 consecutive words. Word k has `out_data`=16'h1000+bitrev(k); for example k=1 gives 16'h1080 and k=2 gives 16'h1040.
  - `out_last` is set only on k=255, and `busy` falls 1 cycle after it.
- Back-pressure: same data, toggle `out_ready` 1,0,0,1,...
  - Outputs hold while not ready.
  - No word is lost or duplicated; the sequence matches the first test.
- Out-of-range and overrun:
  - A write to `wAddress`=9'h100 leaves all entries unchanged.
  - A write during STREAM sets `overrun`=1 and is absent from the stream.
  - The next `fft_start` clears `overrun`.
- Same-cycle events: `sWriteEn` to address 0 with 16'hABCD in the same cycle as `fft_start` gives first word 16'hABCD. A second `fft_start` mid-stream is ignored.
- Reset mid-stream: assert `rst` after 100 words.
  - Next cycle: `out_valid`=0 and `busy`=0.
  - A restart streams from index 0 with the buffer contents intact.
- Without `FFT_INPUT_BITREV_EN`: the first test's data streams as 16'h1000..16'h10FF in order.
